// File: rtl/cim_inst_scheduler.sv
// In-order CIM instruction issue controller: instruction FIFO, destination-tag scoreboard, drain FSM.
// Optional issue/stall statistics counters are built when CIM_SCHED_STATS_EN is defined.
module cim_inst_scheduler #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned MAX_INFLIGHT = 4,
   parameter int unsigned TAG_W        = $clog2(MAX_INFLIGHT),
   parameter int unsigned ADDR_W       = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_inst,
   output logic              iss_valid,
   input  logic              iss_ready,
   output logic [31:0]       iss_inst,
   output logic [TAG_W-1:0]  iss_tag,
   input  logic              cmp_valid,
   input  logic [TAG_W-1:0]  cmp_tag,
   input  logic              drain_req,
   output logic              drain_done,
   output logic              busy,
   output logic              err_tag
`ifdef CIM_SCHED_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [15:0]       stat_issued,
   output logic [15:0]       stat_stall
`endif
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned OP_W  = 32 - 3 * ADDR_W;

   typedef enum logic {ST_RUN, ST_DRAIN} state_e;

   state_e                state_q, state_d;
   logic [31:0]           fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [MAX_INFLIGHT-1:0] sb_vld_q, sb_vld_d;
   logic [ADDR_W-1:0]     sb_d1_q [MAX_INFLIGHT];
   logic                  hold_q, hold_d;
   logic [TAG_W-1:0]      hold_tag_q, hold_tag_d;
   logic                  err_q, err_d;

   logic [31:0]           head;
   logic [ADDR_W-1:0]     head_s1, head_s2, head_d1;
   logic                  empty, full, head_nop, hazard, sb_full, blocked;
   logic                  offer, issue, pop, push, free_found;
   logic [TAG_W-1:0]      free_tag, tag_sel;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign head     = fifo_q[rd_ptr_q];
   assign head_s1  = head[3*ADDR_W-1:2*ADDR_W];
   assign head_s2  = head[2*ADDR_W-1:ADDR_W];
   assign head_d1  = head[ADDR_W-1:0];
   assign head_nop = (head[31 -: OP_W] == '0);
   assign sb_full  = &sb_vld_q;

   // Head hazard against in-flight destinations and lowest free tag, both from registered scoreboard.
   always_comb begin
      hazard     = 1'b0;
      free_found = 1'b0;
      free_tag   = '0;
      for (int unsigned i = 0; i < MAX_INFLIGHT; i++) begin
         if (sb_vld_q[i] && (sb_d1_q[i] == head_s1 || sb_d1_q[i] == head_s2 || sb_d1_q[i] == head_d1))
            hazard = 1'b1;
         if (!sb_vld_q[i] && !free_found) begin
            free_tag   = TAG_W'(i);
            free_found = 1'b1;
         end
      end
   end

   // A held offer keeps its tag even if a lower entry frees up meanwhile.
   assign tag_sel  = hold_q ? hold_tag_q : free_tag;
   assign blocked  = hazard || sb_full;
   assign offer    = !empty && !head_nop && !blocked;
   assign issue    = offer && iss_ready;
   assign pop      = issue || (!empty && head_nop);
   assign push     = in_valid && in_ready;

   assign in_ready  = !full && (state_q == ST_RUN);
   assign iss_valid = offer;
   assign iss_inst  = offer ? head : '0;
   assign iss_tag   = offer ? tag_sel : '0;
   assign busy      = !empty || (|sb_vld_q) || (state_q == ST_DRAIN);
   assign err_tag   = err_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      hold_d     = offer && !iss_ready;
      hold_tag_d = tag_sel;
      sb_vld_d   = sb_vld_q;
      err_d      = err_q;
      if (cmp_valid) begin
         if (sb_vld_q[cmp_tag]) sb_vld_d[cmp_tag] = 1'b0;
         else                   err_d             = 1'b1;
      end
      if (issue) sb_vld_d[tag_sel] = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      drain_done = 1'b0;
      case (state_q)
         ST_RUN:   if (drain_req) state_d = ST_DRAIN;
         ST_DRAIN: if (empty && sb_vld_q == '0) begin
            state_d    = ST_RUN;
            drain_done = 1'b1;
         end
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         sb_vld_q   <= '0;
         hold_q     <= 1'b0;
         hold_tag_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         sb_vld_q   <= sb_vld_d;
         hold_q     <= hold_d;
         hold_tag_q <= hold_tag_d;
         err_q      <= err_d;
      end
   end

   // Storage arrays are qualified by count/valid bits, so they need no reset.
   always_ff @(posedge clk) begin
      if (push)  fifo_q[wr_ptr_q] <= in_inst;
      if (issue) sb_d1_q[tag_sel] <= head_d1;
   end

`ifdef CIM_SCHED_STATS_EN
   logic [15:0] stat_issued_q, stat_issued_d, stat_stall_q, stat_stall_d;
   logic        stall;

   assign stall       = !empty && !head_nop && blocked;
   assign stat_issued = stat_issued_q;
   assign stat_stall  = stat_stall_q;

   always_comb begin
      stat_issued_d = stat_issued_q;
      stat_stall_d  = stat_stall_q;
      if (stat_clr) begin
         stat_issued_d = '0;
         stat_stall_d  = '0;
      end else begin
         if (issue && stat_issued_q != 16'hFFFF) stat_issued_d = stat_issued_q + 16'd1;
         if (stall && stat_stall_q != 16'hFFFF)  stat_stall_d  = stat_stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_issued_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         stat_issued_q <= stat_issued_d;
         stat_stall_q  <= stat_stall_d;
      end
   end
`endif

endmodule

// File: tb/tb_cim_inst_scheduler.sv
// Table-driven bench for cim_inst_scheduler: one row per clock cycle with hand-computed expected outputs.
module tb_cim_inst_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] in_inst;
   logic        iss_valid, iss_ready;
   logic [31:0] iss_inst;
   logic [1:0]  iss_tag;
   logic        cmp_valid;
   logic [1:0]  cmp_tag;
   logic        drain_req, drain_done, busy, err_tag;
`ifdef CIM_SCHED_STATS_EN
   logic        stat_clr = 1'b0;
   logic [15:0] stat_issued, stat_stall;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cim_inst_scheduler dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_inst(iss_inst), .iss_tag(iss_tag),
      .cmp_valid(cmp_valid), .cmp_tag(cmp_tag),
      .drain_req(drain_req), .drain_done(drain_done), .busy(busy), .err_tag(err_tag)
`ifdef CIM_SCHED_STATS_EN
      , .stat_clr(stat_clr), .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
   );

   typedef struct {
      logic        iv;
      logic [31:0] inst;
      logic        ir;
      logic        cv;
      logic [1:0]  ct;
      logic        dr;
      logic        e_rdy;
      logic        e_vld;
      logic [1:0]  e_tag;
      logic [31:0] e_inst;
      logic        e_busy;
      logic        e_done;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [8:0] s1, input logic [8:0] s2,
                                      input logic [8:0] d1);
      return {op, s1, s2, d1};
   endfunction

   function automatic vec_t row(input logic iv, input logic [31:0] inst, input logic ir, input logic cv,
                                input logic [1:0] ct, input logic dr, input logic e_rdy, input logic e_vld,
                                input logic [1:0] e_tag, input logic [31:0] e_inst, input logic e_busy,
                                input logic e_done, input logic e_err);
      vec_t v;
      v.iv = iv; v.inst = inst; v.ir = ir; v.cv = cv; v.ct = ct; v.dr = dr;
      v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_tag = e_tag; v.e_inst = e_inst;
      v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   logic [31:0] i0, a_i, b_i, c1, c2, c3, c4, c5, q1, q2, q3, q4, q5, nop, d1, d2, d3, xi, ri;

   initial begin
      i0 = 32'h0802_0403;
      a_i = mk(5'd1, 9'h010, 9'h011, 9'h005);
      b_i = mk(5'd2, 9'h005, 9'h012, 9'h020);
      c1 = mk(5'd3, 9'h100, 9'h101, 9'h001);
      c2 = mk(5'd3, 9'h100, 9'h101, 9'h002);
      c3 = mk(5'd3, 9'h100, 9'h101, 9'h003);
      c4 = mk(5'd3, 9'h100, 9'h101, 9'h004);
      c5 = mk(5'd3, 9'h100, 9'h101, 9'h009);
      q1 = mk(5'd4, 9'h000, 9'h000, 9'h031);
      q2 = mk(5'd4, 9'h000, 9'h000, 9'h032);
      q3 = mk(5'd4, 9'h000, 9'h000, 9'h033);
      q4 = mk(5'd4, 9'h000, 9'h000, 9'h034);
      q5 = mk(5'd4, 9'h000, 9'h000, 9'h035);
      nop = 32'h0000_0000;
      d1 = mk(5'd5, 9'h000, 9'h000, 9'h040);
      d2 = mk(5'd5, 9'h000, 9'h000, 9'h041);
      d3 = mk(5'd5, 9'h000, 9'h000, 9'h042);
      xi = mk(5'd6, 9'h000, 9'h000, 9'h050);
      ri = mk(5'd7, 9'h000, 9'h000, 9'h060);

      //            iv inst ir cv ct dr | rdy vld tag inst busy done err
      // reset release, first accept and issue
      tbl.push_back(row(1, i0,  0, 0, 0, 0,  1, 0, 0, 0,   0, 0, 0));   // 0
      tbl.push_back(row(0, 0,   1, 0, 0, 0,  1, 1, 0, i0,  1, 0, 0));
      tbl.push_back(row(0, 0,   0, 1, 0, 0,  1, 0, 0, 0,   1, 0, 0));
      tbl.push_back(row(0, 0,   0, 0, 0, 0,  1, 0, 0, 0,   0, 0, 0));
      // RAW stall
      tbl.push_back(row(1, a_i, 1, 0, 0, 0,  1, 0, 0, 0,   0, 0, 0));   // 4
      tbl.push_back(row(1, b_i, 1, 0, 0, 0,  1, 1, 0, a_i, 1, 0, 0));
      tbl.push_back(row(0, 0,   1, 0, 0, 0,  1, 0, 0, 0,   1, 0, 0));
      tbl.push_back(row(0, 0,   1, 0, 0, 0,  1, 0, 0, 0,   1, 0, 0));
      tbl.push_back(row(0, 0,   1, 1, 0, 0,  1, 0, 0, 0,   1, 0, 0));
      tbl.push_back(row(0, 0,   1, 0, 0, 0,  1, 1, 0, b_i, 1, 0, 0));
      tbl.push_back(row(0, 0,   0, 1, 0, 0,  1, 0, 0, 0,   1, 0, 0));
      tbl.push_back(row(0, 0,   0, 0, 0, 0,  1, 0, 0, 0,   0, 0, 0));
      // scoreboard full
      tbl.push_back(row(1, c1,  1, 0, 0, 0,  1, 0, 0, 0,   0, 0, 0));   // 12
      tbl.push_back(row(1, c2,  1, 0, 0, 0,  1, 1, 0, c1,  1, 0, 0));
      tbl.push_back(row(1, c3,  1, 0, 0, 0,  1, 1, 1, c2,  1, 0, 0));
      tbl.push_back(row(1, c4,  1, 0, 0, 0,  1, 1, 2, c3,  1, 0, 0));
      tbl.push_back(row(1, c5,  1, 0, 0, 0,  1, 1, 3, c4,  1, 0, 0));
      tbl.push_back(row(0, 0,   1, 0, 0, 0,  1, 0, 0, 0,   1, 0, 0));
      tbl.push_back(row(0, 0,   1, 1, 2, 0,  1, 0, 0, 0,   1, 0, 0));
      tbl.push_back(row(0, 0,   1, 0, 0, 0,  1, 1, 2, c5,  1, 0, 0));
      tbl.push_back(row(0, 0,   0, 1, 0, 0,  1, 0, 0, 0,   1, 0, 0));   // 20
      tbl.push_back(row(0, 0,   0, 1, 1, 0,  1, 0, 0, 0,   1, 0, 0));
      tbl.push_back(row(0, 0,   0, 1, 2, 0,  1, 0, 0, 0,   1, 0, 0));
      tbl.push_back(row(0, 0,   0, 1, 3, 0,  1, 0, 0, 0,   1, 0, 0));
      tbl.push_back(row(0, 0,   0, 0, 0, 0,  1, 0, 0, 0,   0, 0, 0));
      // queue full with iss_ready low, then reopened
      tbl.push_back(row(1, q1,  0, 0, 0, 0,  1, 0, 0, 0,   0, 0, 0));   // 25
      tbl.push_back(row(1, q2,  0, 0, 0, 0,  1, 1, 0, q1,  1, 0, 0));
      tbl.push_back(row(1, q3,  0, 0, 0, 0,  1, 1, 0, q1,  1, 0, 0));
      tbl.push_back(row(1, q4,  0, 0, 0, 0,  1, 1, 0, q1,  1, 0, 0));
      tbl.push_back(row(1, q5,  0, 0, 0, 0,  0, 1, 0, q1,  1, 0, 0));
      tbl.push_back(row(1, q5,  1, 0, 0, 0,  0, 1, 0, q1,  1, 0, 0));   // 30
      tbl.push_back(row(1, q5,  0, 0, 0, 0,  1, 1, 1, q2,  1, 0, 0));
      tbl.push_back(row(0, 0,   1, 0, 0, 0,  0, 1, 1, q2,  1, 0, 0));
      tbl.push_back(row(0, 0,   1, 0, 0, 0,  1, 1, 2, q3,  1, 0, 0));
      tbl.push_back(row(0, 0,   1, 0, 0, 0,  1, 1, 3, q4,  1, 0, 0));
      tbl.push_back(row(0, 0,   1, 0, 0, 0,  1, 0, 0, 0,   1, 0, 0));
      tbl.push_back(row(0, 0,   1, 1, 0, 0,  1, 0, 0, 0,   1, 0, 0));
      tbl.push_back(row(0, 0,   1, 1, 1, 0,  1, 1, 0, q5,  1, 0, 0));
      tbl.push_back(row(0, 0,   0, 1, 2, 0,  1, 0, 0, 0,   1, 0, 0));
      tbl.push_back(row(0, 0,   0, 1, 3, 0,  1, 0, 0, 0,   1, 0, 0));
      tbl.push_back(row(0, 0,   0, 1, 0, 0,  1, 0, 0, 0,   1, 0, 0));   // 40
      tbl.push_back(row(0, 0,   0, 0, 0, 0,  1, 0, 0, 0,   0, 0, 0));
      // unallocated completion and NOP
      tbl.push_back(row(0, 0,   0, 1, 3, 0,  1, 0, 0, 0,   0, 0, 0));
      tbl.push_back(row(0, 0,   0, 0, 0, 0,  1, 0, 0, 0,   0, 0, 1));
      tbl.push_back(row(1, nop, 0, 0, 0, 0,  1, 0, 0, 0,   0, 0, 1));
      tbl.push_back(row(0, 0,   0, 0, 0, 0,  1, 0, 0, 0,   1, 0, 1));
      tbl.push_back(row(0, 0,   0, 0, 0, 0,  1, 0, 0, 0,   0, 0, 1));   // 46
      // drain with two queued and one in flight
      tbl.push_back(row(1, d1,  0, 0, 0, 0,  1, 0, 0, 0,   0, 0, 1));
      tbl.push_back(row(1, d2,  1, 0, 0, 0,  1, 1, 0, d1,  1, 0, 1));
      tbl.push_back(row(1, d3,  0, 0, 0, 0,  1, 1, 1, d2,  1, 0, 1));
      tbl.push_back(row(0, 0,   0, 0, 0, 1,  1, 1, 1, d2,  1, 0, 1));   // 50
      tbl.push_back(row(1, xi,  1, 0, 0, 0,  0, 1, 1, d2,  1, 0, 1));
      tbl.push_back(row(0, 0,   1, 0, 0, 1,  0, 1, 2, d3,  1, 0, 1));
      tbl.push_back(row(0, 0,   0, 1, 0, 0,  0, 0, 0, 0,   1, 0, 1));
      tbl.push_back(row(0, 0,   0, 1, 1, 0,  0, 0, 0, 0,   1, 0, 1));
      tbl.push_back(row(0, 0,   0, 1, 2, 0,  0, 0, 0, 0,   1, 0, 1));
      tbl.push_back(row(0, 0,   0, 0, 0, 0,  0, 0, 0, 0,   1, 1, 1));
      tbl.push_back(row(0, 0,   0, 0, 0, 0,  1, 0, 0, 0,   0, 0, 1));
      // drain request while idle
      tbl.push_back(row(0, 0,   0, 0, 0, 1,  1, 0, 0, 0,   0, 0, 1));
      tbl.push_back(row(0, 0,   0, 0, 0, 0,  0, 0, 0, 0,   1, 1, 1));
      tbl.push_back(row(0, 0,   0, 0, 0, 0,  1, 0, 0, 0,   0, 0, 1));   // 60

      // reset held with in_valid high: nothing accepted, outputs idle
      rst = 1'b1; in_valid = 1'b1; in_inst = i0; iss_ready = 1'b0;
      cmp_valid = 1'b0; cmp_tag = '0; drain_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset iss_valid", 32'(iss_valid), 32'd0);
      chk("reset iss_inst", iss_inst, 32'd0);
      chk("reset iss_tag", 32'(iss_tag), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset drain_done", 32'(drain_done), 32'd0);
      chk("reset err_tag", 32'(err_tag), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         in_valid = tbl[i].iv; in_inst = tbl[i].inst; iss_ready = tbl[i].ir;
         cmp_valid = tbl[i].cv; cmp_tag = tbl[i].ct; drain_req = tbl[i].dr;
         #1;
         chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
         chk($sformatf("row%0d iss_valid", i), 32'(iss_valid), 32'(tbl[i].e_vld));
         chk($sformatf("row%0d iss_tag", i), 32'(iss_tag), 32'(tbl[i].e_tag));
         chk($sformatf("row%0d iss_inst", i), iss_inst, tbl[i].e_inst);
         chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
         chk($sformatf("row%0d drain_done", i), 32'(drain_done), 32'(tbl[i].e_done));
         chk($sformatf("row%0d err_tag", i), 32'(err_tag), 32'(tbl[i].e_err));
`ifdef CIM_SCHED_STATS_EN
         if (i == 46) chk("stat_issued after nop", 32'(stat_issued), 32'd13);
`endif
         @(negedge clk);
      end

      // reset mid-operation discards the queued instruction and the sticky error
      in_valid = 1'b1; in_inst = ri; iss_ready = 1'b0;
      cmp_valid = 1'b0; drain_req = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("pre-reset iss_valid", 32'(iss_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("midreset iss_valid", 32'(iss_valid), 32'd0);
      chk("midreset busy", 32'(busy), 32'd0);
      chk("midreset in_ready", 32'(in_ready), 32'd1);
      chk("midreset err_tag", 32'(err_tag), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post-reset busy", 32'(busy), 32'd0);
      chk("post-reset iss_valid", 32'(iss_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
